core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RISC-V core datapath (PC, instruction memory, decoder, register file, branch comparator, EX). It splits each instruction into FETCH / EXEC / MEM / WB phases and gates the PC update and register write-enable. It also runs a request/acknowledge handshake with a variable-latency data memory and supports run / single-step / halt-on-timeout control.

---
 rtl/core_seq_ctrl_pkg.sv | 22 ++
 rtl/core_seq_ctrl_if.sv | 31 +++
 rtl/core_seq_ctrl_mem_wait_timer.sv | 26 ++
 rtl/core_seq_ctrl.sv | 111 +++++++++++
 tb/tb_core_seq_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and constants for the core sequencer: state encodings,
// writeback-select values and the retired-instruction counter width.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    localparam logic [1:0] WB_MEM    = 2'b00;
    localparam int         INSTRET_W = 32;

    // A load writes back memory data and is not a store.
    function automatic logic is_load(input logic [1:0] wbsel, input logic memwe);
        return (wbsel == WB_MEM) && !memwe;
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Decoder inputs, data-memory handshake and status outputs of the sequencer.
// slave = sequencer side, master = datapath/testbench side.
interface core_seq_ctrl_if;
    import core_ctrl_pkg::*;

    logic                 run;
    logic                 step;
    logic                 RegWE_i;
    logic                 MemWE_i;
    logic [1:0]           WBSel_i;
    logic                 mem_ack;
    logic                 mem_req;
    logic                 mem_we;
    logic                 pc_en;
    logic                 reg_we;
    logic                 busy;
    logic [2:0]           state;
    logic                 timeout;
    logic [INSTRET_W-1:0] instret;

    modport slave (
        input  run, step, RegWE_i, MemWE_i, WBSel_i, mem_ack,
        output mem_req, mem_we, pc_en, reg_we, busy, state, timeout, instret
    );

    modport master (
        output run, step, RegWE_i, MemWE_i, WBSel_i, mem_ack,
        input  mem_req, mem_we, pc_en, reg_we, busy, state, timeout, instret
    );

endinterface

// File: rtl/core_seq_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on the data memory; expired flags count == MAX.
module mem_wait_timer #(
    parameter int MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_expired = (r_cnt == W'(MAX));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with data-memory handshake and timeout.
// Optional macro CORE_SEQ_INSTRET_EN adds the retired-instruction counter.
module core_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    core_seq_ctrl_if.slave io_bus
);
    state_e r_state;
    logic   r_we_l, r_st_l;
    logic   r_mem_req, r_pc_en, r_busy, r_timeout;
    logic   w_ld, w_expired, w_tmr_clr, w_tmr_inc;

    assign w_ld      = is_load(io_bus.WBSel_i, io_bus.MemWE_i);
    assign w_tmr_clr = (r_state == S_EXEC);
    assign w_tmr_inc = (r_state == S_MEM) && !io_bus.mem_ack;

    mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_tmr_inc),
        .o_expired (w_expired)
    );

    // Strobes are registered on the transition into their state, so decoder
    // inputs never reach an output within the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_we_l    <= 1'b0;
            r_st_l    <= 1'b0;
            r_mem_req <= 1'b0;
            r_pc_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_pc_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.run || io_bus.step) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_EXEC;
                S_EXEC: begin
                    r_we_l <= io_bus.RegWE_i;
                    r_st_l <= io_bus.MemWE_i;
                    if (io_bus.MemWE_i || w_ld) begin
                        r_state   <= S_MEM;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state <= S_WB;
                        r_pc_en <= 1'b1;
                    end
                end
                S_MEM: begin
                    // An ack arriving on the expiry cycle still completes the access.
                    if (io_bus.mem_ack) begin
                        r_state   <= S_WB;
                        r_mem_req <= 1'b0;
                        r_pc_en   <= 1'b1;
                    end else if (w_expired) begin
                        r_state   <= S_HALT;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                S_WB: begin
                    if (io_bus.run) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.state   = r_state;
    assign io_bus.mem_req = r_mem_req;
    assign io_bus.mem_we  = r_mem_req & r_st_l;
    assign io_bus.pc_en   = r_pc_en;
    assign io_bus.reg_we  = r_pc_en & r_we_l;
    assign io_bus.busy    = r_busy;
    assign io_bus.timeout = r_timeout;

`ifdef CORE_SEQ_INSTRET_EN
    logic [INSTRET_W-1:0] r_instret;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_instret <= '0;
        else if (r_state == S_WB)
            r_instret <= r_instret + INSTRET_W'(1);
    end

    assign io_bus.instret = r_instret;
`else
    assign io_bus.instret = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Trace-driven bench for core_seq_ctrl: per-cycle {inputs, expected outputs}
// records built from instruction-level timing rules, directed and random.
module tb_core_seq_ctrl;
    import core_ctrl_pkg::*;

    localparam int MAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    core_seq_ctrl_if bus ();

    core_seq_ctrl #(.MEM_WAIT_MAX(MAX)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    typedef struct {
        logic       run, step, rwe, mwe;
        logic [1:0] wbs;
        logic       ack;
        logic [2:0] st;
        logic       req, we, pc, rw, bsy, to;
    } cyc_t;

    cyc_t        tr[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] m_instret = 32'd0;

    function automatic logic [31:0] exp_ir();
`ifdef CORE_SEQ_INSTRET_EN
        return m_instret;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Random inputs everywhere; expectations default to an idle, non-busy cycle.
    function automatic cyc_t junk();
        cyc_t c;
        c.run = 1'($urandom); c.step = 1'($urandom);
        c.rwe = 1'($urandom); c.mwe  = 1'($urandom);
        c.wbs = 2'($urandom); c.ack  = 1'($urandom);
        c.st  = 3'd0; c.req = 1'b0; c.we = 1'b0; c.pc = 1'b0;
        c.rw  = 1'b0; c.bsy = 1'b0; c.to = 1'b0;
        return c;
    endfunction

    task automatic add_idle(input logic run, input logic step);
        cyc_t c;
        c = junk(); c.run = run; c.step = step;
        tr.push_back(c);
    endtask

    // n = ack delay in MEM cycles; n > MAX means the ack never arrives.
    task automatic add_instr(input bit from_idle, input bit use_step, input bit next_run,
                             input logic rwe, input logic mwe, input logic [1:0] wbs,
                             input int n);
        cyc_t c;
        if (from_idle) add_idle(!use_step, use_step);
        c = junk(); c.st = 3'd1; c.bsy = 1'b1;
        if (use_step) c.step = 1'b1;
        tr.push_back(c);
        c = junk(); c.st = 3'd2; c.bsy = 1'b1; c.rwe = rwe; c.mwe = mwe; c.wbs = wbs;
        tr.push_back(c);
        if (mwe || wbs == 2'b00) begin
            for (int k = 0; k <= n && k <= MAX; k++) begin
                c = junk(); c.st = 3'd3; c.bsy = 1'b1; c.req = 1'b1; c.we = mwe;
                c.ack = (k == n);
                tr.push_back(c);
            end
            if (n > MAX) begin
                for (int k = 0; k < 6; k++) begin
                    c = junk(); c.st = 3'd5; c.to = 1'b1;
                    if (k < 2) begin c.run = 1'b1; c.step = 1'b1; c.ack = 1'b1; end
                    tr.push_back(c);
                end
                return;
            end
        end
        c = junk(); c.st = 3'd4; c.bsy = 1'b1; c.pc = 1'b1; c.rw = rwe; c.run = next_run;
        tr.push_back(c);
    endtask

    task automatic apply(input int lim);
        for (int i = 0; i < tr.size() && i < lim; i++) begin
            chk($sformatf("state@%0d", i),   32'(bus.state),   32'(tr[i].st));
            chk($sformatf("mem_req@%0d", i), 32'(bus.mem_req), 32'(tr[i].req));
            chk($sformatf("mem_we@%0d", i),  32'(bus.mem_we),  32'(tr[i].we));
            chk($sformatf("pc_en@%0d", i),   32'(bus.pc_en),   32'(tr[i].pc));
            chk($sformatf("reg_we@%0d", i),  32'(bus.reg_we),  32'(tr[i].rw));
            chk($sformatf("busy@%0d", i),    32'(bus.busy),    32'(tr[i].bsy));
            chk($sformatf("timeout@%0d", i), 32'(bus.timeout), 32'(tr[i].to));
            chk($sformatf("instret@%0d", i), bus.instret,      exp_ir());
            bus.run = tr[i].run; bus.step = tr[i].step; bus.mem_ack = tr[i].ack;
            bus.RegWE_i = tr[i].rwe; bus.MemWE_i = tr[i].mwe; bus.WBSel_i = tr[i].wbs;
            @(posedge clk); #1;
            if (tr[i].st == 3'd4) m_instret = m_instret + 32'd1;
        end
        tr.delete();
    endtask

    task automatic do_reset();
        bus.run = 1'b0; bus.step = 1'b0; bus.mem_ack = 1'b0;
        bus.RegWE_i = 1'b0; bus.MemWE_i = 1'b0; bus.WBSel_i = 2'b00;
        rst_n = 1'b0;
        #1;
        m_instret = 32'd0;
        chk("rst_state",   32'(bus.state),   32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
        chk("rst_pc_en",   32'(bus.pc_en),   32'd0);
        chk("rst_reg_we",  32'(bus.reg_we),  32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_instret", bus.instret,      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit prev_run;
        #2;
        do_reset();

        // ALU x3 back-to-back, load with ack after 2, single step, store acks at 0 and MAX.
        add_instr(1, 0, 1, 1'b1, 1'b0, 2'b01, 0);
        add_instr(0, 0, 1, 1'b1, 1'b0, 2'b01, 0);
        add_instr(0, 0, 0, 1'b1, 1'b0, 2'b01, 0);
        add_idle(0, 0);
        add_instr(1, 0, 0, 1'b1, 1'b0, 2'b00, 2);
        add_idle(0, 0);
        add_instr(1, 1, 0, 1'b1, 1'b0, 2'b10, 0);
        add_idle(0, 0); add_idle(0, 0);
        add_instr(1, 0, 0, 1'b0, 1'b1, 2'b01, 0);
        add_instr(1, 0, 0, 1'b0, 1'b1, 2'b11, MAX);
        add_idle(0, 0);
        apply(1 << 30);

        // Store that never gets an ack: timeout and absorbing HALT.
        add_instr(1, 0, 0, 1'b0, 1'b1, 2'b11, MAX + 1);
        apply(1 << 30);
        do_reset();

        // One ALU instruction, then asynchronous reset in the middle of a store's MEM phase.
        add_instr(1, 0, 1, 1'b1, 1'b0, 2'b01, 0);
        add_instr(0, 0, 0, 1'b0, 1'b1, 2'b01, 5);
        apply(8);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        chk("pre_rst_mem_we",  32'(bus.mem_we),  32'd1);
        chk("pre_rst_instret", bus.instret,      exp_ir());
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("async_rst_state",   32'(bus.state),   32'd0);
        chk("async_rst_instret", bus.instret,      32'd0);
        chk("async_rst_before_edge", 32'(clk), 32'd1);
        m_instret = 32'd0;
        do_reset();

        // Random instruction mix with random ack delays, run drops and step starts.
        prev_run = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bit nr, us;
            nr = ($urandom_range(0, 3) != 0);
            us = prev_run ? 1'b0 : 1'($urandom);
            add_instr(!prev_run, us, nr, 1'($urandom), 1'($urandom), 2'($urandom),
                      $urandom_range(0, MAX));
            if (!nr && $urandom_range(0, 1) == 1) add_idle(0, 0);
            prev_run = nr;
        end
        apply(1 << 30);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
